// File: rtl/noc_traffic_gen.sv
// ============================================================================
// noc_traffic_gen
// ----------------------------------------------------------------------------
// Synthetic traffic generator and sink for one PE port of the OpenNoC mesh.
// The transmit side injects numPackets packets to pseudo-random destinations
// (never this node) through a valid/ready port. Each new injection starts at
// least `rate` cycles after the previous one. The receive side counts every
// delivered packet and raises a sticky error flag when a packet arrives that
// is addressed to some other node.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   start       in   run request (level); low in DONE returns to IDLE
//   enable_send in   gates new assertions of o_valid only
//   o_valid     out  injection valid
//   o_data      out  injected packet {payload, dest_y, dest_x}
//   i_ready     in   router ready; transfer when o_valid & i_ready
//   i_valid     in   delivered packet valid (no backpressure)
//   i_data      in   delivered packet
//   done        out  high only in DONE (all packets injected)
//   sent_count  out  accepted injections this run (saturating)
//   recv_count  out  delivered packets since reset (saturating)
//   err         out  sticky misroute flag, cleared only by rst
// ============================================================================
module noc_traffic_gen #(
   parameter int          X          = 2,
   parameter int          Y          = 2,
   parameter int          x_size     = $clog2(X),
   parameter int          y_size     = $clog2(Y),
   parameter int          data_width = 256,
   parameter int          numPackets = 1000,
   parameter int          rate       = 1,
   parameter int          MY_X       = 0,
   parameter int          MY_Y       = 0,
   parameter logic [15:0] SEED       = 16'hACE1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic                                enable_send,
   output logic                                o_valid,
   output logic [x_size+y_size+data_width-1:0] o_data,
   input  logic                                i_ready,
   input  logic                                i_valid,
   input  logic [x_size+y_size+data_width-1:0] i_data,
   output logic                                done,
   output logic [31:0]                         sent_count,
   output logic [31:0]                         recv_count,
   output logic                                err
);

   localparam int          TW       = x_size + y_size + data_width;
   localparam int          DEST_W   = x_size + y_size;
   localparam logic [x_size-1:0] C_MY_X = x_size'(MY_X);
   localparam logic [y_size-1:0] C_MY_Y = y_size'(MY_Y);
   localparam logic [15:0] C_SEED   = (SEED == 16'h0000) ? 16'hACE1 : SEED;
   localparam logic [31:0] C_NUM    = 32'(numPackets);
   // The gap counter is loaded on the assertion cycle, so it must count
   // rate-1 further cycles before the next launch is allowed.
   localparam logic [31:0] C_GAP    = 32'(rate - 1);
   localparam logic [31:0] C_MAX    = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [15:0]       r_lfsr;
   logic              r_valid;
   logic [TW-1:0]     r_data;
   logic [31:0]       r_sent;
   logic [31:0]       r_recv;
   logic              r_err;
   logic [31:0]       r_gap;

   logic              w_fire;
   logic              w_last;
   logic              w_launch;
   logic              w_clear_sent;
   logic [31:0]       w_sent_inc;
   logic [31:0]       w_sent_next;
   logic [15:0]       w_lfsr_next;
   logic [x_size-1:0] w_dx_raw;
   logic [x_size-1:0] w_dx;
   logic [y_size-1:0] w_dy;
   logic [TW-1:0]     w_pkt;
   logic              w_rx_dest_ok;
   logic              w_unused_rx;

   // Galois form of x^16+x^14+x^13+x^11+1 (right shift, toggle mask 0xB400).
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      lfsr_step = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
   endfunction

   // ------------------------------------------------------------------------
   // Transmit datapath
   // ------------------------------------------------------------------------
   assign w_fire     = r_valid & i_ready;
   assign w_sent_inc = (r_sent == C_MAX) ? r_sent : r_sent + 32'd1;
   assign w_last     = w_fire && (w_sent_inc == C_NUM);

   // A packet launched on the same edge as a transfer must see the state
   // that transfer produces: stepped LFSR and incremented sequence number.
   assign w_lfsr_next = w_fire ? lfsr_step(r_lfsr) : r_lfsr;
   assign w_sent_next = w_clear_sent ? 32'd0 : (w_fire ? w_sent_inc : r_sent);

   assign w_dx_raw = w_lfsr_next[x_size-1:0];
   assign w_dy     = w_lfsr_next[DEST_W-1:x_size];
   // X is a power of two, so the x_size-bit add wraps modulo X.
   assign w_dx     = ((w_dx_raw == C_MY_X) && (w_dy == C_MY_Y)) ?
                     w_dx_raw + x_size'(1) : w_dx_raw;

   always_comb begin
      w_pkt = '0;
      w_pkt[0 +: x_size]                = w_dx;
      w_pkt[x_size +: y_size]           = w_dy;
      w_pkt[DEST_W +: x_size]           = C_MY_X;
      w_pkt[DEST_W + x_size +: y_size]  = C_MY_Y;
      w_pkt[2*DEST_W +: 16]             = w_sent_next[15:0];
   end

   // ------------------------------------------------------------------------
   // Control FSM: next state and launch decision
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_launch     = 1'b0;
      w_clear_sent = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               if (C_NUM == 32'd0) begin
                  w_state_next = DONE;
               end else begin
                  w_state_next = SEND;
                  // Each run counts its own packets from zero.
                  w_clear_sent = 1'b1;
               end
            end
         end
         SEND: begin
            if (w_last) begin
               w_state_next = DONE;
            end else if (enable_send && (r_gap == 32'd0) &&
                         (!r_valid || w_fire)) begin
               w_launch = 1'b1;
            end
         end
         DONE: begin
            if (!start) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_lfsr  <= C_SEED;
         r_valid <= 1'b0;
         r_data  <= '0;
         r_sent  <= 32'd0;
         r_gap   <= 32'd0;
      end else begin
         r_state <= w_state_next;
         r_lfsr  <= w_lfsr_next;
         r_sent  <= w_sent_next;
         // A pending packet is only ever retired by a transfer; enable_send
         // and start affect launches, never an outstanding o_valid.
         if (w_launch) begin
            r_valid <= 1'b1;
            r_data  <= w_pkt;
         end else if (w_fire) begin
            r_valid <= 1'b0;
         end
         if (w_launch) begin
            r_gap <= C_GAP;
         end else if (r_gap != 32'd0) begin
            r_gap <= r_gap - 32'd1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Receive sink (independent of the transmit side)
   // ------------------------------------------------------------------------
   assign w_rx_dest_ok = (i_data[x_size-1:0] == C_MY_X) &&
                         (i_data[DEST_W-1:x_size] == C_MY_Y);
   // Payload of delivered packets is not inspected.
   assign w_unused_rx  = ^i_data[TW-1:DEST_W];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_recv <= 32'd0;
         r_err  <= 1'b0;
      end else if (i_valid) begin
         if (r_recv != C_MAX) begin
            r_recv <= r_recv + 32'd1;
         end
         if (!w_rx_dest_ok) begin
            r_err <= 1'b1;
         end
      end
   end

   assign o_valid    = r_valid;
   assign o_data     = r_data;
   assign done       = (r_state == DONE);
   assign sent_count = r_sent;
   assign recv_count = r_recv;
   assign err        = r_err;

endmodule

// File: tb/tb_noc_traffic_gen.sv
// ============================================================================
// tb_noc_traffic_gen
// Two generators share the clock and reset:
//   u_dut_a : rate 1, 8 packets, node (1,0), default seed
//   u_dut_b : rate 4, 6 packets, node (0,1), seed 0 (replaced by 0xACE1)
// Expected packets are produced by a small LFSR/packet model and queued when
// a run is started; they are popped as the DUT hands packets over.
// ============================================================================
module tb_noc_traffic_gen;

   localparam int XS   = 1;
   localparam int YS   = 1;
   localparam int DW   = 32;
   localparam int TW   = XS + YS + DW;
   localparam int NP_A = 8;
   localparam int NP_B = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          start_a, en_a, rdy_a, ivalid_a;
   logic [TW-1:0] idata_a;
   logic          ovalid_a, done_a, err_a;
   logic [TW-1:0] odata_a;
   logic [31:0]   sent_a, recv_a;
   logic          start_b, en_b, rdy_b, ivalid_b;
   logic [TW-1:0] idata_b;
   logic          ovalid_b, done_b, err_b;
   logic [TW-1:0] odata_b;
   logic [31:0]   sent_b, recv_b;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0]   m_lfsr_a = 16'hACE1;
   logic [15:0]   m_lfsr_b = 16'hACE1;
   logic [TW-1:0] exp_q_a[$];
   logic [TW-1:0] exp_q_b[$];
   logic [32:0]   exp_rx_q[$];
   int            m_recv_a = 0;
   logic          m_err_a  = 1'b0;

   noc_traffic_gen #(
      .X(2), .Y(2), .data_width(DW), .numPackets(NP_A), .rate(1),
      .MY_X(1), .MY_Y(0), .SEED(16'hACE1)
   ) u_dut_a (
      .clk(clk), .rst(rst), .start(start_a), .enable_send(en_a),
      .o_valid(ovalid_a), .o_data(odata_a), .i_ready(rdy_a),
      .i_valid(ivalid_a), .i_data(idata_a), .done(done_a),
      .sent_count(sent_a), .recv_count(recv_a), .err(err_a)
   );

   noc_traffic_gen #(
      .X(2), .Y(2), .data_width(DW), .numPackets(NP_B), .rate(4),
      .MY_X(0), .MY_Y(1), .SEED(16'h0000)
   ) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b), .enable_send(en_b),
      .o_valid(ovalid_b), .o_data(odata_b), .i_ready(rdy_b),
      .i_valid(ivalid_b), .i_data(idata_b), .done(done_b),
      .sent_count(sent_b), .recv_count(recv_b), .err(err_b)
   );

   // ---------------------------------------------------------------- model
   function automatic logic [15:0] model_step(input logic [15:0] s);
      logic fb;
      fb = s[0];
      s  = s >> 1;
      if (fb) s = s ^ 16'hB400;
      return s;
   endfunction

   function automatic logic [TW-1:0] model_pkt(input logic [15:0] lf,
                                               input int seq, input int mx,
                                               input int my);
      logic [TW-1:0] p;
      int dx, dy;
      dx = int'(lf) % (1 << XS);
      dy = (int'(lf) >> XS) % (1 << YS);
      if (dx == mx && dy == my) dx = (dx + 1) % (1 << XS);
      p = '0;
      p[XS-1:0]          = dx[XS-1:0];
      p[XS+YS-1:XS]      = dy[YS-1:0];
      p[XS+YS +: XS]     = mx[XS-1:0];
      p[2*XS+YS +: YS]   = my[YS-1:0];
      p[2*XS+2*YS +: 16] = seq[15:0];
      return p;
   endfunction

   task automatic push_run_a();
      for (int i = 0; i < NP_A; i++) begin
         exp_q_a.push_back(model_pkt(m_lfsr_a, i, 1, 0));
         m_lfsr_a = model_step(m_lfsr_a);
      end
   endtask

   task automatic push_run_b();
      for (int i = 0; i < NP_B; i++) begin
         exp_q_b.push_back(model_pkt(m_lfsr_b, i, 0, 1));
         m_lfsr_b = model_step(m_lfsr_b);
      end
   endtask

   function automatic logic [TW-1:0] pop_a();
      if (exp_q_a.size() == 0) return 'x;
      return exp_q_a.pop_front();
   endfunction

   function automatic logic [TW-1:0] pop_b();
      if (exp_q_b.size() == 0) return 'x;
      return exp_q_b.pop_front();
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      rst = 1'b1;
      start_a = 1'b0; en_a = 1'b0; rdy_a = 1'b0; ivalid_a = 1'b0; idata_a = '0;
      start_b = 1'b0; en_b = 1'b0; rdy_b = 1'b0; ivalid_b = 1'b0; idata_b = '0;
      for (int c = 0; c < 23; c++) begin
         if (c == 3) rst = 1'b0;
         tick();
         n_checks++;
         if ({ovalid_a, odata_a, done_a, sent_a, recv_a, err_a,
              ovalid_b, odata_b, done_b, sent_b, recv_b, err_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_idle cyc %0d: a v=%b d=%h dn=%b s=%0d r=%0d e=%b b v=%b d=%h dn=%b s=%0d r=%0d e=%b, want all 0",
                     c, ovalid_a, odata_a, done_a, sent_a, recv_a, err_a,
                     ovalid_b, odata_b, done_b, sent_b, recv_b, err_b);
         end
      end
   endtask

   task automatic test_full_rate();
      int xfers, gaps;
      logic [TW-1:0] exp;
      push_run_a();
      rdy_a = 1'b1; en_a = 1'b1; start_a = 1'b1;
      tick();
      n_checks++;
      if (ovalid_a !== 1'b0) begin
         n_fail++;
         $display("FAIL start_latency_n got o_valid=%b want 0", ovalid_a);
      end
      tick();
      n_checks++;
      if (ovalid_a !== 1'b1) begin
         n_fail++;
         $display("FAIL start_latency_n1 got o_valid=%b want 1", ovalid_a);
      end
      xfers = 0; gaps = 0;
      for (int c = 0; c < 40 && xfers < NP_A; c++) begin
         if (ovalid_a) begin
            exp = pop_a();
            n_checks++;
            if (odata_a !== exp) begin
               n_fail++;
               $display("FAIL full_pkt[%0d] got %h want %h", xfers, odata_a, exp);
            end
            n_checks++;
            if (odata_a[1:0] === 2'b01) begin
               n_fail++;
               $display("FAIL full_self_dest[%0d] got dest %b want not 01", xfers, odata_a[1:0]);
            end
            xfers++;
         end else begin
            gaps++;
         end
         tick();
      end
      n_checks++;
      if (xfers != NP_A) begin
         n_fail++;
         $display("FAIL full_count got %0d transfers want %0d", xfers, NP_A);
      end
      n_checks++;
      if (gaps != 0) begin
         n_fail++;
         $display("FAIL full_back_to_back got %0d idle cycles want 0", gaps);
      end
      n_checks++;
      if ({done_a, ovalid_a} !== 2'b10) begin
         n_fail++;
         $display("FAIL full_done got done=%b o_valid=%b want 1,0", done_a, ovalid_a);
      end
      n_checks++;
      if (sent_a !== 32'd8) begin
         n_fail++;
         $display("FAIL full_sent got %0d want 8", sent_a);
      end
   endtask

   task automatic test_restart();
      start_a = 1'b0;
      tick();
      n_checks++;
      if ({done_a, ovalid_a} !== 2'b00) begin
         n_fail++;
         $display("FAIL restart_idle got done=%b o_valid=%b want 0,0", done_a, ovalid_a);
      end
   endtask

   task automatic test_backpressure();
      logic found;
      logic [TW-1:0] held, exp;
      logic [31:0] s0;
      int xfers;
      push_run_a();
      rdy_a = 1'b0; start_a = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         tick();
         found = ovalid_a;
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL bp_valid_timeout got o_valid=%b want 1", ovalid_a);
      end
      held = odata_a; s0 = sent_a;
      for (int c = 0; c < 5; c++) begin
         tick();
         n_checks++;
         if (ovalid_a !== 1'b1 || odata_a !== held || sent_a !== s0) begin
            n_fail++;
            $display("FAIL bp_stall[%0d] got v=%b d=%h s=%0d want v=1 d=%h s=%0d",
                     c, ovalid_a, odata_a, sent_a, held, s0);
         end
      end
      rdy_a = 1'b1;
      xfers = 0;
      for (int c = 0; c < 40 && xfers < NP_A; c++) begin
         if (ovalid_a) begin
            exp = pop_a();
            n_checks++;
            if (odata_a !== exp) begin
               n_fail++;
               $display("FAIL bp_pkt[%0d] got %h want %h", xfers, odata_a, exp);
            end
            xfers++;
         end
         tick();
      end
      n_checks++;
      if (done_a !== 1'b1 || sent_a !== 32'd8) begin
         n_fail++;
         $display("FAIL bp_done got done=%b sent=%0d want 1,8", done_a, sent_a);
      end
      start_a = 1'b0;
      tick();
   endtask

   task automatic test_sink();
      logic [32:0] exp;
      for (int k = 0; k < 4; k++) begin
         idata_a = '0;
         idata_a[TW-1:2] = 32'($urandom);
         idata_a[1:0] = (k < 3) ? 2'b01 : 2'b00;
         ivalid_a = 1'b1;
         m_recv_a++;
         if (k == 3) m_err_a = 1'b1;
         exp_rx_q.push_back({m_err_a, 32'(m_recv_a)});
         tick();
         exp = exp_rx_q.pop_front();
         n_checks++;
         if ({err_a, recv_a} !== exp) begin
            n_fail++;
            $display("FAIL sink[%0d] got err=%b recv=%0d want err=%b recv=%0d",
                     k, err_a, recv_a, exp[32], exp[31:0]);
         end
      end
      ivalid_a = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         n_checks++;
         if (err_a !== 1'b1 || recv_a !== 32'd4) begin
            n_fail++;
            $display("FAIL sink_sticky[%0d] got err=%b recv=%0d want 1,4", c, err_a, recv_a);
         end
      end
   endtask

   task automatic test_rate_gating();
      int cyc, last, rises, xfers;
      logic prev, found;
      logic [TW-1:0] held, exp;
      push_run_b();
      rdy_b = 1'b1; en_b = 1'b1; start_b = 1'b1;
      cyc = 0; last = 0; rises = 0; prev = 1'b0;
      for (int c = 0; c < 60 && rises < 3; c++) begin
         tick(); cyc++;
         if (ovalid_b && !prev) begin
            if (rises > 0) begin
               n_checks++;
               if (cyc - last != 4) begin
                  n_fail++;
                  $display("FAIL rate_spacing[%0d] got %0d want 4", rises, cyc - last);
               end
            end
            last = cyc; rises++;
         end
         if (ovalid_b && rdy_b) begin
            exp = pop_b();
            n_checks++;
            if (odata_b !== exp) begin
               n_fail++;
               $display("FAIL rate_pkt[%0d] got %h want %h", rises - 1, odata_b, exp);
            end
         end
         prev = ovalid_b;
      end
      tick(); cyc++;
      rdy_b = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         tick(); cyc++;
         found = ovalid_b;
      end
      n_checks++;
      if (!found || cyc - last != 4) begin
         n_fail++;
         $display("FAIL rate_spacing_4th got found=%b spacing=%0d want 1,4", found, cyc - last);
      end
      held = odata_b;
      en_b = 1'b0;
      for (int c = 0; c < 2; c++) begin
         tick();
         n_checks++;
         if (ovalid_b !== 1'b1 || odata_b !== held) begin
            n_fail++;
            $display("FAIL gate_pending[%0d] got v=%b d=%h want v=1 d=%h", c, ovalid_b, odata_b, held);
         end
      end
      rdy_b = 1'b1;
      exp = pop_b();
      n_checks++;
      if (odata_b !== exp) begin
         n_fail++;
         $display("FAIL gate_pkt got %h want %h", odata_b, exp);
      end
      tick();
      for (int c = 0; c < 10; c++) begin
         n_checks++;
         if (ovalid_b !== 1'b0) begin
            n_fail++;
            $display("FAIL gate_hold[%0d] got o_valid=%b want 0", c, ovalid_b);
         end
         tick();
      end
      en_b = 1'b1;
      xfers = 0;
      for (int c = 0; c < 30 && xfers < 2; c++) begin
         if (ovalid_b) begin
            exp = pop_b();
            n_checks++;
            if (odata_b !== exp) begin
               n_fail++;
               $display("FAIL gate_tail_pkt[%0d] got %h want %h", xfers, odata_b, exp);
            end
            xfers++;
         end
         tick();
      end
      n_checks++;
      if ({done_b, ovalid_b} !== 2'b10 || sent_b !== 32'd6) begin
         n_fail++;
         $display("FAIL rate_done got done=%b v=%b sent=%0d want 1,0,6", done_b, ovalid_b, sent_b);
      end
      start_b = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_send();
      logic found;
      logic [31:0] s0, r0;
      logic [TW-1:0] exp;
      rdy_a = 1'b1; en_a = 1'b1; start_a = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         tick();
         found = ovalid_a;
      end
      tick(); tick();
      s0 = sent_a; r0 = recv_a;
      idata_a = '0; idata_a[1:0] = 2'b01; ivalid_a = 1'b1;
      tick();
      ivalid_a = 1'b0;
      n_checks++;
      if (!found || sent_a !== s0 + 32'd1 || recv_a !== r0 + 32'd1) begin
         n_fail++;
         $display("FAIL simul_tx_rx got sent=%0d recv=%0d want %0d,%0d",
                  sent_a, recv_a, s0 + 32'd1, r0 + 32'd1);
      end
      rst = 1'b1;
      tick();
      n_checks++;
      if ({ovalid_a, done_a, sent_a, recv_a, err_a} !== '0) begin
         n_fail++;
         $display("FAIL mid_reset got v=%b done=%b sent=%0d recv=%0d err=%b want all 0",
                  ovalid_a, done_a, sent_a, recv_a, err_a);
      end
      rst = 1'b0; start_a = 1'b0;
      m_lfsr_a = 16'hACE1;
      exp_q_a.delete();
      tick();
      start_a = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         tick();
         found = ovalid_a;
      end
      exp = model_pkt(m_lfsr_a, 0, 1, 0);
      n_checks++;
      if (!found || odata_a !== exp) begin
         n_fail++;
         $display("FAIL reseed_pkt got v=%b d=%h want v=1 d=%h", found, odata_a, exp);
      end
      start_a = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_full_rate();
      test_restart();
      test_backpressure();
      test_sink();
      test_rate_gating();
      test_reset_mid_send();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
